// File: rtl/fpu_pkg.sv
// Shared single-precision FP constants, field layout and helper types.
// Optional feature macro: FP_MUL_RNE_EN (round-to-nearest-even; otherwise truncate).
package fpu_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Derived widths: 24x24 product, signed exponent sum with headroom, packed word
    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int ESUM_W = EXP_W + 2;
    localparam int FLT_W  = EXP_W + MAN_W + 1;

    // Packed-float field offsets
    localparam int SIGN_POS = EXP_W + MAN_W;
    localparam int EXP_LSB  = MAN_W;
    localparam int MAN_LSB  = 0;

    // Special-value field constants
    localparam logic [EXP_W-1:0] EXP_INF   = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0] MAN_ZERO  = {MAN_W{1'b0}};

    // Signed exponent thresholds for the post-rounding range check
    localparam logic signed [ESUM_W-1:0] EXP_MAX_S = ESUM_W'(EXP_MAX);
    localparam logic signed [ESUM_W-1:0] EXP_MIN_S = ESUM_W'(0);
    localparam logic signed [ESUM_W-1:0] EXP_ONE_S = ESUM_W'(1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

    // Normalized, not-yet-rounded operand held between the two stages
    typedef struct packed {
        logic                     sign;
        logic signed [ESUM_W-1:0] exp;
        logic [MAN_W-1:0]         mant;
`ifdef FP_MUL_RNE_EN
        logic                     guard;
        logic                     sticky;
`endif
        logic                     zero;
    } norm_t;

    function automatic fp_word_t pack_fp(input logic sign,
                                         input logic [EXP_W-1:0] exp,
                                         input logic [MAN_W-1:0] man);
        fp_word_t w;
        w.sign = sign;
        w.exp  = exp;
        w.man  = man;
        return w;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational rounding, exponent range check and IEEE-754 packing.
// Shared by the multiplier and adder result paths.
// Optional feature macro: FP_MUL_RNE_EN (round-to-nearest-even; otherwise truncate).
module fp_round_pack
    import fpu_pkg::*;
(
    input  logic                     sign,
    input  logic signed [ESUM_W-1:0] exp,
    input  logic [MAN_W-1:0]         mant,
`ifdef FP_MUL_RNE_EN
    input  logic                     guard,
    input  logic                     sticky,
`endif
    input  logic                     zero,
    output logic [FLT_W-1:0]         result,
    output logic                     ovf,
    output logic                     unf
);

    logic signed [ESUM_W-1:0] exp_rnd_s;
    logic [MAN_W-1:0]         mant_rnd_s;
    fp_word_t                 word_s;

`ifdef FP_MUL_RNE_EN
    logic inc_s;
    logic carry_s;

    // Round to nearest, ties to even; a mantissa carry-out bumps the exponent
    always_comb begin
        inc_s                = guard & (sticky | mant[0]);
        {carry_s, mant_rnd_s} = {1'b0, mant} + {{MAN_W{1'b0}}, inc_s};
        exp_rnd_s            = exp + $signed({{(ESUM_W-1){1'b0}}, carry_s});
    end
`else
    // Truncation: the normalized mantissa and exponent pass straight through
    always_comb begin
        mant_rnd_s = mant;
        exp_rnd_s  = exp;
    end
`endif

    // Range check in priority order: zero operand, overflow, underflow, normal
    always_comb begin
        word_s = pack_fp(sign, EXP_ZERO, MAN_ZERO);
        ovf    = 1'b0;
        unf    = 1'b0;
        if (zero) begin
            word_s = pack_fp(sign, EXP_ZERO, MAN_ZERO);
        end else if (exp_rnd_s >= EXP_MAX_S) begin
            word_s = pack_fp(sign, EXP_INF, MAN_ZERO);
            ovf    = 1'b1;
        end else if (exp_rnd_s <= EXP_MIN_S) begin
            // No subnormal output: flush to signed zero
            word_s = pack_fp(sign, EXP_ZERO, MAN_ZERO);
            unf    = 1'b1;
        end else begin
            word_s = pack_fp(sign, exp_rnd_s[EXP_W-1:0], mant_rnd_s);
        end
    end

    assign result = word_s;

endmodule

// File: rtl/fp_mul_norm_round.sv
// Final FP multiplier stage: normalize the 48-bit product (stage 1), then
// round, range-check and pack (stage 2). Valid/ready on both sides.
// Optional feature macro: FP_MUL_RNE_EN (round-to-nearest-even; otherwise truncate).
module fp_mul_norm_round
    import fpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sign_in,
    input  logic signed [ESUM_W-1:0] exp_sum,
    input  logic [PROD_W-1:0]        prod,
    input  logic                     zero_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FLT_W-1:0]         result,
    output logic                     ovf,
    output logic                     unf
);

    norm_t            norm_s;
    norm_t            s1_r;
    logic             s1_valid_r;
    logic             s2_valid_r;
    logic [FLT_W-1:0] result_r;
    logic             ovf_r;
    logic             unf_r;
    logic             s2_advance_s;
    logic [FLT_W-1:0] rp_result_s;
    logic             rp_ovf_s;
    logic             rp_unf_s;

`ifndef FP_MUL_RNE_EN
    // Product bits below the kept mantissa only matter when rounding
    logic unused_prod_lsb_s;
    assign unused_prod_lsb_s = ^prod[PROD_W-3-MAN_W:0];
`endif

    // Stage 2 takes a new beat when empty or when its current one is consumed;
    // stage 1 accepts when empty or draining into stage 2.
    assign s2_advance_s = ~s2_valid_r | out_ready;
    assign in_ready     = ~s1_valid_r | s2_advance_s;

    // Normalize: product in [1,4) -> shift by one when the top bit is set
    always_comb begin
        norm_s      = '0;
        norm_s.sign = sign_in;
        norm_s.zero = zero_in;
        if (prod[PROD_W-1]) begin
            norm_s.mant   = prod[PROD_W-2 -: MAN_W];
            norm_s.exp    = exp_sum + EXP_ONE_S;
`ifdef FP_MUL_RNE_EN
            norm_s.guard  = prod[PROD_W-2-MAN_W];
            norm_s.sticky = |prod[PROD_W-3-MAN_W:0];
`endif
        end else begin
            norm_s.mant   = prod[PROD_W-3 -: MAN_W];
            norm_s.exp    = exp_sum;
`ifdef FP_MUL_RNE_EN
            norm_s.guard  = prod[PROD_W-3-MAN_W];
            norm_s.sticky = |prod[PROD_W-4-MAN_W:0];
`endif
        end
    end

    // Stage 1 register: captures the normalized beat on an input handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_r <= norm_s;
            end
        end
    end

    fp_round_pack u_round_pack (
        .sign   (s1_r.sign),
        .exp    (s1_r.exp),
        .mant   (s1_r.mant),
`ifdef FP_MUL_RNE_EN
        .guard  (s1_r.guard),
        .sticky (s1_r.sticky),
`endif
        .zero   (s1_r.zero),
        .result (rp_result_s),
        .ovf    (rp_ovf_s),
        .unf    (rp_unf_s)
    );

    // Stage 2 register: holds the packed result stable until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= '0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else if (s2_advance_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= rp_result_s;
                ovf_r    <= rp_ovf_s;
                unf_r    <= rp_unf_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Scoreboard bench for fp_mul_norm_round: stimulus pushes expected results
// from an arithmetic reference model; a monitor pops and compares outputs.
// Follows FP_MUL_RNE_EN the same way as the design.
module tb_fp_mul_norm_round;
    import fpu_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     sign_in = 1'b0;
    logic signed [ESUM_W-1:0] exp_sum = '0;
    logic [PROD_W-1:0]        prod = '0;
    logic                     zero_in = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [FLT_W-1:0]         result;
    logic                     ovf;
    logic                     unf;

    int n_cmp = 0;
    int n_err = 0;
    logic [33:0] sb_q[$];
    bit bp_rand = 1'b0;
    bit or_force = 1'b1;

    fp_mul_norm_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_sum(exp_sum), .prod(prod), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // out_ready is driven only here: random backpressure or a forced level
    always @(negedge clk) begin
        out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_force;
    end

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value-level normalize/round/range check, returns {ovf,unf,result}
    function automatic logic [33:0] ref_model(input logic s, input int e_sum,
                                              input logic [47:0] p, input logic z);
        longint unsigned pv, keep;
        int sh, e;
`ifdef FP_MUL_RNE_EN
        longint unsigned rem, half;
`endif
        if (z) return {2'b00, s, 31'd0};
        pv   = p;
        sh   = (pv >= (64'd1 << 47)) ? 1 : 0;
        keep = pv >> (23 + sh);
        e    = e_sum + sh;
`ifdef FP_MUL_RNE_EN
        rem  = pv - (keep << (23 + sh));
        half = 64'd1 << (22 + sh);
        if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e    = e + 1;
        end
`endif
        if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (e <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, e[7:0], keep[22:0]};
    endfunction

    // Offer one beat until accepted (bounded), pushing its expected result
    task automatic send(input logic s, input int e, input logic [47:0] p, input logic z);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1; sign_in = s; exp_sum = e[ESUM_W-1:0]; prod = p; zero_in = z;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk); #1; w++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end else begin
            sb_q.push_back(ref_model(s, e, p, z));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk); #1;
        or_force = v;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb_q.size() != 0 && w < 300) begin
            @(negedge clk); w++;
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compare every transferred output against the scoreboard head
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got %h expected no beat", {ovf, unf, result});
                end else begin
                    e = sb_q.pop_front();
                    check("beat", {ovf, unf, result}, e);
                end
            end
        end
    end

    function automatic logic [47:0] rand_prod();
        logic [23:0] mx, my;
        mx = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        my = 24'h800000 | 24'($urandom_range(0, 24'h7FFFFF));
        if ($urandom_range(0, 3) == 0) mx[11:0] = 12'h000;
        if ($urandom_range(0, 3) == 0) my[11:0] = 12'h000;
        return 48'(mx) * 48'(my);
    endfunction

    function automatic int rand_exp();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 10)) - 5;
            1: return int'($urandom_range(245, 258));
            2: return int'($urandom_range(1, 254));
            default: return int'($urandom_range(0, 400)) - 20;
        endcase
    endfunction

    initial begin
        logic [47:0] bp_prod[4];
        int          bp_exp[4];
        logic [31:0] held;
        int k, w;

        // Reset state
        #12;
        check("rst_out_valid", {33'd0, out_valid}, 34'd0);
        check("rst_result", {2'b00, result}, 34'd0);
        check("rst_flags", {32'd0, ovf, unf}, 34'd0);
        check("rst_in_ready", {33'd0, in_ready}, 34'd1);
        @(negedge clk); #3 rst = 1'b0;

        // Latency: 1.5*1.5 appears exactly two edges after acceptance
        send(1'b0, 127, 48'h900000000000, 1'b0);
        check("lat_cycle1_valid", {33'd0, out_valid}, 34'd0);
        @(posedge clk); #1;
        check("lat_cycle2_valid", {33'd0, out_valid}, 34'd1);
        check("lat_result", {ovf, unf, result}, {2'b00, 32'h40100000});

        // Directed boundary cases
        send(1'b0, 127, 48'h400000C00000, 1'b0);
`ifdef FP_MUL_RNE_EN
        check("tie_model", ref_model(1'b0, 127, 48'h400000C00000, 1'b0), {2'b00, 32'h3F800002});
`else
        check("tie_model", ref_model(1'b0, 127, 48'h400000C00000, 1'b0), {2'b00, 32'h3F800001});
`endif
        send(1'b1, 254, 48'h800000000000, 1'b0);
        send(1'b0, 0, 48'h400000000000, 1'b0);
        send(1'b1, 200, rand_prod(), 1'b1);
        send(1'b0, 254, 48'h7FFFFFFFFFFF, 1'b0);
        send(1'b0, 1, 48'h400000000000, 1'b0);
        send(1'b1, 0, 48'h800000000000, 1'b0);
        send(1'b0, -3, 48'hC00000000000, 1'b0);
        wait_drain();

        // Backpressure: 4 beats offered over 5 held cycles -> only 2 accepted
        for (int i = 0; i < 4; i++) begin
            bp_prod[i] = rand_prod();
            bp_exp[i]  = int'($urandom_range(20, 230));
        end
        set_ready(1'b0);
        k = 0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1; sign_in = k[0]; exp_sum = bp_exp[k][ESUM_W-1:0];
            prod = bp_prod[k]; zero_in = 1'b0;
            #1;
            if (c == 2) held = result;
            if (c > 2) check("bp_stable", {2'b00, result}, {2'b00, held});
            if (c >= 2) check("bp_out_valid", {33'd0, out_valid}, 34'd1);
            if (in_ready) begin
                sb_q.push_back(ref_model(k[0], bp_exp[k], bp_prod[k], 1'b0));
                k++;
            end
        end
        check("bp_accepted", 34'(k), 34'd2);
        check("bp_in_ready", {33'd0, in_ready}, 34'd0);
        or_force = 1'b1;
        w = 0;
        while (k < 4 && w < 20) begin
            @(negedge clk);
            in_valid = 1'b1; sign_in = k[0]; exp_sum = bp_exp[k][ESUM_W-1:0];
            prod = bp_prod[k];
            #1;
            if (in_ready) begin
                sb_q.push_back(ref_model(k[0], bp_exp[k], bp_prod[k], 1'b0));
                k++;
            end
            w++;
        end
        @(posedge clk); #1 in_valid = 1'b0;
        check("bp_all_sent", 34'(k), 34'd4);
        wait_drain();

        // Reset with both stages full: outputs clear asynchronously, nothing stale after
        set_ready(1'b0);
        send(1'b0, 100, rand_prod(), 1'b0);
        send(1'b1, 110, rand_prod(), 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rstmid_out_valid", {33'd0, out_valid}, 34'd0);
        check("rstmid_in_ready", {33'd0, in_ready}, 34'd1);
        sb_q.delete();
        @(negedge clk); @(negedge clk); #3 rst = 1'b0;
        or_force = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check("rstmid_no_stale", {33'd0, out_valid}, 34'd0);
        end

        // Randomized traffic with random backpressure
        bp_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(1'($urandom_range(0, 1)), rand_exp(), rand_prod(),
                 ($urandom_range(0, 15) == 0));
        end
        bp_rand = 1'b0;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
